// File: rtl/obz_bank_turn.sv
// Registered tristate output bank. All pads share one enable FSM.
// Before the bank drives, the FSM inserts a programmable turnaround dead time.
// Release is immediate: T, TSALL and TMASK gate the pads combinationally.
module obz_bank_turn #(
  parameter int unsigned      WIDTH  = 8,
  parameter int unsigned      TURN   = 2,
  parameter logic [WIDTH-1:0] INIT_O = '0
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             CE,
  input  logic [WIDTH-1:0] I,
  input  logic             T,
  input  logic [WIDTH-1:0] TMASK,
  input  logic             TSALL,
  output wire  [WIDTH-1:0] O,
  output logic             OE,
  output logic             BUSY
);

  // The counter is at least one bit wide, so that TURN=0 still elaborates.
  localparam int unsigned     CntW    = (TURN < 2) ? 1 : $clog2(TURN + 1);
  localparam logic [CntW-1:0] CntLoad = (TURN == 0) ? '0 : CntW'(TURN - 1);

  typedef enum logic [1:0] {
    StHiz,
    StTurnWait,
    StDrive
  } state_e;

  state_e           state;
  logic [CntW-1:0]  cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] en;
  logic             release_req;

  assign release_req = T | TSALL;

  // Output data register; it captures only on CE.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      q <= INIT_O;
    end else if (CE) begin
      q <= I;
    end
  end

  // Enable FSM. OE and BUSY are registered alongside the state.
  // A release request wins over every enabling condition in the same cycle.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= StHiz;
      cnt   <= '0;
      OE    <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      case (state)
        StHiz: begin
          if (!release_req && CE) begin
            if (TURN == 0) begin
              state <= StDrive;
              OE    <= 1'b1;
            end else begin
              state <= StTurnWait;
              BUSY  <= 1'b1;
              cnt   <= CntLoad;
            end
          end
        end
        StTurnWait: begin
          if (release_req) begin
            state <= StHiz;
            BUSY  <= 1'b0;
          end else if (CE) begin
            if (cnt == '0) begin
              state <= StDrive;
              BUSY  <= 1'b0;
              OE    <= 1'b1;
            end else begin
              cnt <= cnt - CntW'(1);
            end
          end
        end
        StDrive: begin
          if (release_req) begin
            state <= StHiz;
            OE    <= 1'b0;
          end
        end
        default: begin
          state <= StHiz;
          OE    <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel enable. The release terms bypass the FSM, so the pads float immediately.
  always_comb begin
    en = '0;
    for (int k = 0; k < int'(WIDTH); k++) begin
      en[k] = OE & ~T & ~TSALL & ~TMASK[k];
    end
  end

  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_pad
    assign O[g] = en[g] ? q[g] : 1'bz;
  end

endmodule

// File: tb/tb_obz_bank_turn.sv
// Directed bench for obz_bank_turn.
// It has three instances (TURN = 2, 0 and 3) that share one set of inputs.
module tb_obz_bank_turn;

  logic       clk;
  logic       rstn;
  logic       ce;
  logic       t;
  logic       tsall;
  logic [7:0] din;
  logic [7:0] tmask;
  wire  [7:0] o2;
  wire  [7:0] o0;
  wire  [7:0] o3;
  logic       oe2, busy2, oe0, busy0, oe3, busy3;

  int checks;
  int fails;

  logic [7:0] zz;
  logic [7:0] exp_mask;

  obz_bank_turn #(.WIDTH(8), .TURN(2), .INIT_O(8'hA5)) u_turn2 (
    .CLK(clk), .RSTN(rstn), .CE(ce), .I(din), .T(t), .TMASK(tmask), .TSALL(tsall),
    .O(o2), .OE(oe2), .BUSY(busy2)
  );

  obz_bank_turn #(.WIDTH(8), .TURN(0), .INIT_O(8'hA5)) u_turn0 (
    .CLK(clk), .RSTN(rstn), .CE(ce), .I(din), .T(t), .TMASK(tmask), .TSALL(tsall),
    .O(o0), .OE(oe0), .BUSY(busy0)
  );

  obz_bank_turn #(.WIDTH(8), .TURN(3), .INIT_O(8'hA5)) u_turn3 (
    .CLK(clk), .RSTN(rstn), .CE(ce), .I(din), .T(t), .TMASK(tmask), .TSALL(tsall),
    .O(o3), .OE(oe3), .BUSY(busy3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    t    = 1'b1;
    rstn = 1'b0;
    #1;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; ce = 1'b1; t = 1'b0; tsall = 1'b0; din = 8'h3C; tmask = 8'h00;
    #3;
    checks++; if (o2 !== zz) begin fails++; $display("FAIL rst_o: got %h want %h", o2, zz); end
    checks++; if (oe2 !== 1'b0) begin fails++; $display("FAIL rst_oe: got %b want 0", oe2); end
    checks++; if (busy2 !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy2); end
    tick();
    rstn = 1'b1;
    tick();  // edge k
    checks++; if (busy2 !== 1'b1) begin fails++; $display("FAIL en_busy_k: got %b want 1", busy2); end
    checks++; if (oe2 !== 1'b0) begin fails++; $display("FAIL en_oe_k: got %b want 0", oe2); end
    tick();  // edge k+1
    checks++; if (busy2 !== 1'b1) begin fails++; $display("FAIL en_busy_k1: got %b want 1", busy2); end
    checks++; if (o2 !== zz) begin fails++; $display("FAIL en_o_k1: got %h want %h", o2, zz); end
    tick();  // edge k+2
    checks++; if (oe2 !== 1'b1) begin fails++; $display("FAIL en_oe_k2: got %b want 1", oe2); end
    checks++; if (busy2 !== 1'b0) begin fails++; $display("FAIL en_busy_k2: got %b want 0", busy2); end
    checks++; if (o2 !== 8'h3C) begin fails++; $display("FAIL en_o_k2: got %h want 3c", o2); end
  endtask

  task automatic test_turn0();
    din = 8'h3C; ce = 1'b1; tsall = 1'b0;
    do_reset();
    checks++; if (oe0 !== 1'b0) begin fails++; $display("FAIL t0_hold: got %b want 0", oe0); end
    t = 1'b0;
    tick();  // edge k
    checks++; if (oe0 !== 1'b1) begin fails++; $display("FAIL t0_oe: got %b want 1", oe0); end
    checks++; if (busy0 !== 1'b0) begin fails++; $display("FAIL t0_busy: got %b want 0", busy0); end
    checks++; if (o0 !== 8'h3C) begin fails++; $display("FAIL t0_o: got %h want 3c", o0); end
    tick();
    checks++; if (busy0 !== 1'b0) begin fails++; $display("FAIL t0_busy2: got %b want 0", busy0); end
    tick();  // u_turn2 reaches DRIVE at k+2
  endtask

  task automatic test_data();
    din = 8'h5A;
    tick();
    checks++; if (o2 !== 8'h5A) begin fails++; $display("FAIL data_cap: got %h want 5a", o2); end
    ce = 1'b0; din = 8'hFF;
    tick();
    checks++; if (o2 !== 8'h5A) begin fails++; $display("FAIL data_hold: got %h want 5a", o2); end
    checks++; if (oe2 !== 1'b1) begin fails++; $display("FAIL data_oe: got %b want 1", oe2); end
    ce = 1'b1; din = 8'h3C;
    tick();
    checks++; if (o2 !== 8'h3C) begin fails++; $display("FAIL data_recap: got %h want 3c", o2); end
  endtask

  task automatic test_release();
    // A short T pulse between edges floats the pads but leaves the FSM alone.
    #2 t = 1'b1;
    #1;
    checks++; if (o2 !== zz) begin fails++; $display("FAIL pulse_z: got %h want %h", o2, zz); end
    t = 1'b0;
    #1;
    checks++; if (o2 !== 8'h3C) begin fails++; $display("FAIL pulse_back: got %h want 3c", o2); end
    tick();
    checks++; if (oe2 !== 1'b1) begin fails++; $display("FAIL pulse_oe: got %b want 1", oe2); end
    #2 t = 1'b1;
    #1;
    checks++; if (o2 !== zz) begin fails++; $display("FAIL rel_z: got %h want %h", o2, zz); end
    checks++; if (oe2 !== 1'b1) begin fails++; $display("FAIL rel_oe_same: got %b want 1", oe2); end
    tick();
    checks++; if (oe2 !== 1'b0) begin fails++; $display("FAIL rel_oe_next: got %b want 0", oe2); end
    t = 1'b0;
    tick();
    checks++; if (busy2 !== 1'b1) begin fails++; $display("FAIL rel_busy_k: got %b want 1", busy2); end
    tick();
    checks++; if (oe2 !== 1'b0) begin fails++; $display("FAIL rel_oe_k1: got %b want 0", oe2); end
    tick();
    checks++; if (o2 !== 8'h3C) begin fails++; $display("FAIL rel_o_k2: got %h want 3c", o2); end
  endtask

  task automatic test_tsall();
    tsall = 1'b1;
    #1;
    checks++; if (o2 !== zz) begin fails++; $display("FAIL tsall_z: got %h want %h", o2, zz); end
    tick();
    checks++; if (oe2 !== 1'b0) begin fails++; $display("FAIL tsall_oe: got %b want 0", oe2); end
    tick();  // TSALL wins over T=0, CE=1 in HIZ
    checks++; if (busy2 !== 1'b0) begin fails++; $display("FAIL tsall_prio: got %b want 0", busy2); end
    tsall = 1'b0;
    tick();
    checks++; if (busy2 !== 1'b1) begin fails++; $display("FAIL tsall_busy: got %b want 1", busy2); end
    tick();
    checks++; if (oe2 !== 1'b0) begin fails++; $display("FAIL tsall_oe_k1: got %b want 0", oe2); end
    tick();
    checks++; if (oe2 !== 1'b1) begin fails++; $display("FAIL tsall_oe_k2: got %b want 1", oe2); end
  endtask

  task automatic test_stall_mask();
    din = 8'h3C; ce = 1'b1; tsall = 1'b0; tmask = 8'h00;
    do_reset();
    t = 1'b0;
    tick();  // edge k
    checks++; if (busy3 !== 1'b1) begin fails++; $display("FAIL st_busy_k: got %b want 1", busy3); end
    ce = 1'b0;
    tick();
    tick();
    checks++; if (busy3 !== 1'b1) begin fails++; $display("FAIL st_busy_stall: got %b want 1", busy3); end
    ce = 1'b1;
    tick();
    tick();  // k+4: unstalled would already drive
    checks++; if (oe3 !== 1'b0) begin fails++; $display("FAIL st_oe_k4: got %b want 0", oe3); end
    checks++; if (busy3 !== 1'b1) begin fails++; $display("FAIL st_busy_k4: got %b want 1", busy3); end
    tick();  // k+5
    checks++; if (oe3 !== 1'b1) begin fails++; $display("FAIL st_oe_k5: got %b want 1", oe3); end
    checks++; if (o3 !== 8'h3C) begin fails++; $display("FAIL st_o_k5: got %h want 3c", o3); end
    tmask = 8'h0F;
    #1;
    checks++;
    if (o3 !== exp_mask) begin fails++; $display("FAIL mask_o: got %h want %h", o3, exp_mask); end
    tick();
    checks++; if (oe3 !== 1'b1) begin fails++; $display("FAIL mask_oe: got %b want 1", oe3); end
    tmask = 8'h00;
  endtask

  task automatic test_reset_mid();
    din = 8'h3C; ce = 1'b1; tsall = 1'b0;
    do_reset();
    t = 1'b0;
    tick();
    checks++; if (busy2 !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b want 1", busy2); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (busy2 !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b want 0", busy2); end
    checks++; if (oe2 !== 1'b0) begin fails++; $display("FAIL mid_rst_oe: got %b want 0", oe2); end
    tick();
    din  = 8'hC3;
    rstn = 1'b1;
    tick();
    checks++; if (busy2 !== 1'b1) begin fails++; $display("FAIL mid2_busy_k: got %b want 1", busy2); end
    tick();
    checks++; if (oe2 !== 1'b0) begin fails++; $display("FAIL mid2_oe_k1: got %b want 0", oe2); end
    tick();
    checks++; if (oe2 !== 1'b1) begin fails++; $display("FAIL mid2_oe_k2: got %b want 1", oe2); end
    checks++; if (o2 !== 8'hC3) begin fails++; $display("FAIL mid2_o: got %h want c3", o2); end
  endtask

  initial begin
    checks   = 0;
    fails    = 0;
    zz       = 8'bzzzz_zzzz;
    exp_mask = 8'b0011_zzzz;
    test_reset();
    test_turn0();
    test_data();
    test_release();
    test_tsall();
    test_stall_mask();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
